lsu_byte_sequencer: RTL and testbench
=====================================

Name: lsu_byte_sequencer

Overview:
- Requester side of the byte-addressed data-memory interface.
- Accepts one load/store request from the core over a valid/ready handshake.
- Serialises the request into 1, 2 or 4 single-byte memory accesses, little-endian, one byte per cycle.
- For loads, assembles the bytes and sign- or zero-extends the result before returning it to the core.
- Sits between the execute stage and a byte-wide data memory with combinational read and synchronous write.

Parameters:
- MEM_BYTES, 1024, size of the addressable byte memory; accesses touching bytes at or beyond this limit are errors.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request
- req_write  in  1  1 = store, 0 = load
- req_ctrl  in  3  access size/type: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address of the lowest byte
- req_wdata  in  32  store data; low bytes used
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  32  load result (0 for stores and errors)
- resp_err  out  1  valid with resp_valid: illegal ctrl or out-of-range access
- mem_addr  out  32  byte address to memory
- mem_we  out  1  byte write enable
- mem_wdata  out  8  byte write data
- mem_rdata  in  8  byte read data, combinational from mem_addr

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - Reset is synchronous and active-low on `rst_n`.
  - Reset values: state IDLE, req_ready 1, resp_valid 0, resp_err 0, resp_rdata 0, mem_we 0, mem_addr 0, mem_wdata 0, byte index 0.
- States:
  - IDLE:
    - req_ready = 1.
    - On req_valid, latch write, ctrl, addr and wdata. Set byte count N = 1 (ctrl[1:0]=00), 2 (01) or 4 (10).
    - Illegal cases, checked at accept time:
      - ctrl in {011, 110, 111}, or a store with ctrl[2]=1, is illegal.
      - addr + N - 1 >= MEM_BYTES (32-bit compare, no wrap) is out of range.
      - Either case goes to RESP with err=1 and performs no memory access.
    - Otherwise go to ACCESS with idx=0.
  - ACCESS:
    - req_ready = 0.
    - mem_addr = latched addr + idx.
    - Store: mem_we = 1 and mem_wdata = wdata[8*idx+7 : 8*idx].
    - Load: mem_we = 0, and mem_rdata is captured into byte lane idx of the assembly register at the clock edge.
    - Increment idx. When idx = N-1, go to RESP.
  - RESP:
    - resp_valid = 1 for exactly one cycle, then return to IDLE. req_ready = 0.
    - Load result:
      - B: sign-extend bit 7.
      - H: sign-extend bit 15.
      - W: all 32 bits.
      - BU / HU: zero-extend.
    - Store or error result: resp_rdata = 0.
    - resp_rdata and resp_err hold their values until the next RESP.
- Latency, counted from the accept edge to the cycle resp_valid is high:
  - N+1 cycles for a legal access.
  - 1 cycle for an error.
  - Throughput is one request per N+2 cycles.
- Outputs:
  - mem_addr, mem_we and mem_wdata are decoded only from registered state. No combinational path runs from req_* to mem_*.
  - In IDLE and RESP: mem_we = 0, mem_addr = 0.
- Misaligned accesses are legal and are not split specially; bytes are sequential.
- req_* inputs are ignored outside IDLE, and changes to them after acceptance have no effect.
- Reset mid-ACCESS:
  - Returns to IDLE at that edge; mem_we is low from the next cycle.
  - Bytes already written stay in memory. No resp_valid is issued.

Test Plan:
- SW addr 0x10, data 0xA1B2C3D4 -> mem_we high 4 cycles, bytes D4, C3, B2, A1 at 0x10..0x13. resp_valid 5 cycles after accept, err 0, rdata 0.
- LW at 0x10 after the store above -> resp_rdata 0xA1B2C3D4. Then LH at 0x12 -> 0xFFFFA1B2. LHU at 0x12 -> 0x0000A1B2. LB at 0x11 -> 0xFFFFFFC3. LBU at 0x11 -> 0x000000C3. Each returns N+1 cycles after accept.
- SH at misaligned addr 0x21 with data 0x0000BEEF -> bytes EF at 0x21 and BE at 0x22. Byte 0x20 is unchanged.
- LW at 0x3FE with MEM_BYTES = 1024 -> resp_err 1 and rdata 0 one cycle after accept; mem_we stays low throughout.
- ctrl 011 load, and ctrl 100 store -> resp_err 1; no memory write occurs.
- Mid-sequence checks:
  - rst_n low during the 3rd ACCESS cycle of SW 0x55667788 at 0x40 -> 0x40 and 0x41 are written, 0x42 and 0x43 are not. No resp_valid is issued, and req_ready is 1 the cycle after reset.
  - req_valid held high back-to-back -> the second request is accepted only in IDLE.

Source files
------------

// File: rtl/lsu_byte_sequencer.sv
// Byte-serial load/store sequencer between the execute stage and a byte-wide data memory.
// Splits B/H/W requests into little-endian single-byte accesses and extends load results.
//
// state  | meaning
// IDLE   | ready for a request; memory interface quiet
// ACCESS | one byte access per cycle, idx selects the byte lane
// RESP   | one-cycle response pulse, then back to IDLE
module lsu_byte_sequencer #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_ctrl,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic        write_q;
    logic [2:0]  ctrl_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] asm_q;
    logic [1:0]  idx;
    logic [1:0]  last_idx;
    logic        we_q;

    logic [1:0]  req_last;
    logic        ctrl_bad;
    logic        range_bad;
    logic [32:0] req_end;
    logic [1:0]  idx_nxt;
    logic [7:0]  wbyte_nxt;
    logic [31:0] asm_full;
    logic [31:0] load_val;

    always_comb begin
        case (req_ctrl[1:0])
            2'b00:   req_last = 2'd0;
            2'b01:   req_last = 2'd1;
            default: req_last = 2'd3;
        endcase
    end

    assign ctrl_bad  = (req_ctrl == 3'b011) || (req_ctrl == 3'b110) || (req_ctrl == 3'b111)
                     || (req_write && req_ctrl[2]);
    // 33-bit sum so an address near 2^32 cannot wrap back into range
    assign req_end   = {1'b0, req_addr} + {31'd0, req_last};
    assign range_bad = req_end >= 33'(MEM_BYTES);

    assign idx_nxt = idx + 2'd1;

    always_comb begin
        case (idx_nxt)
            2'd0:    wbyte_nxt = wdata_q[7:0];
            2'd1:    wbyte_nxt = wdata_q[15:8];
            2'd2:    wbyte_nxt = wdata_q[23:16];
            default: wbyte_nxt = wdata_q[31:24];
        endcase
    end

    // assembly register with the byte arriving this cycle merged in
    always_comb begin
        asm_full = asm_q;
        case (idx)
            2'd0:    asm_full[7:0]   = mem_rdata;
            2'd1:    asm_full[15:8]  = mem_rdata;
            2'd2:    asm_full[23:16] = mem_rdata;
            default: asm_full[31:24] = mem_rdata;
        endcase
    end

    always_comb begin
        case (ctrl_q)
            3'b000:  load_val = {{24{asm_full[7]}}, asm_full[7:0]};
            3'b001:  load_val = {{16{asm_full[15]}}, asm_full[15:0]};
            3'b100:  load_val = {24'd0, asm_full[7:0]};
            3'b101:  load_val = {16'd0, asm_full[15:0]};
            default: load_val = asm_full;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            we_q       <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 8'd0;
            idx        <= 2'd0;
            last_idx   <= 2'd0;
            write_q    <= 1'b0;
            ctrl_q     <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            asm_q      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        ctrl_q    <= req_ctrl;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        last_idx  <= req_last;
                        idx       <= 2'd0;
                        asm_q     <= 32'd0;
                        req_ready <= 1'b0;
                        if (ctrl_bad || range_bad) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            state     <= ACCESS;
                            mem_addr  <= req_addr;
                            we_q      <= req_write;
                            mem_wdata <= req_wdata[7:0];
                        end
                    end
                end
                ACCESS: begin
                    if (!write_q) asm_q <= asm_full;
                    if (idx == last_idx) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= write_q ? 32'd0 : load_val;
                        we_q       <= 1'b0;
                        mem_addr   <= 32'd0;
                        mem_wdata  <= 8'd0;
                    end else begin
                        idx       <= idx_nxt;
                        mem_addr  <= addr_q + {30'd0, idx_nxt};
                        mem_wdata <= wbyte_nxt;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    idx        <= 2'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // a reset arriving mid-store abandons the byte in flight rather than committing it
    assign mem_we = we_q & rst_n;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Bench for lsu_byte_sequencer: byte memory, a transaction-level reference model scored
// every cycle, and directed requests with hand-computed results.
`timescale 1ns/1ps
module tb_lsu_byte_sequencer;
    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_ctrl;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    always #5 clk = ~clk;

    lsu_byte_sequencer #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_ctrl   (req_ctrl),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    logic [7:0] mem [0:MEM_BYTES-1];
    logic [7:0] ref_mem [0:MEM_BYTES-1];

    always @(posedge clk) begin
        if (mem_we && mem_addr < MEM_BYTES) mem[mem_addr[9:0]] <= mem_wdata;
    end

    always_comb mem_rdata = (mem_addr < MEM_BYTES) ? mem[mem_addr[9:0]] : 8'h00;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // expected behaviour per cycle number, filled in when the model accepts a request
    bit          e_we   [int];
    logic [31:0] e_addr [int];
    logic [7:0]  e_wd   [int];
    bit          e_rv   [int];
    bit          e_err  [int];
    logic [31:0] e_rd   [int];
    int          busy_end = -1;

    int          m_c, m_a, m_n;
    bit          m_bad, m_ew;
    logic [31:0] m_ea, m_ba;
    longint      m_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_mem(input logic [31:0] a, input logic [7:0] exp);
        check($sformatf("mem[0x%0h]", a), 32'(mem[a[9:0]]), 32'(exp));
    endtask

    task automatic model_cycle();
        m_c = cyc;
        if (m_c >= 1) begin
            m_ew = (e_we.exists(m_c) ? e_we[m_c] : 1'b0) && rst_n;
            m_ea = e_addr.exists(m_c) ? e_addr[m_c] : 32'd0;
            check("req_ready", 32'(req_ready), 32'(m_c > busy_end));
            check("mem_we", 32'(mem_we), 32'(m_ew));
            check("mem_addr", mem_addr, m_ea);
            if (m_ew) check("mem_wdata", 32'(mem_wdata), 32'(e_wd[m_c]));
            check("resp_valid", 32'(resp_valid), 32'(e_rv.exists(m_c)));
            if (e_rv.exists(m_c)) begin
                check("resp_err", 32'(resp_err), 32'(e_err[m_c]));
                check("resp_rdata", resp_rdata, e_rd[m_c]);
            end
            if (m_ew) ref_mem[m_ea[9:0]] = e_wd[m_c];
        end
        if (!rst_n) begin
            for (int k = m_c + 1; k <= m_c + 8; k++) begin
                if (e_we.exists(k))   e_we.delete(k);
                if (e_addr.exists(k)) e_addr.delete(k);
                if (e_wd.exists(k))   e_wd.delete(k);
                if (e_rv.exists(k))   e_rv.delete(k);
                if (e_err.exists(k))  e_err.delete(k);
                if (e_rd.exists(k))   e_rd.delete(k);
            end
            busy_end = m_c;
        end else if (m_c > busy_end && req_valid) begin
            m_a   = m_c + 1;
            m_n   = (req_ctrl[1:0] == 2'b00) ? 1 : (req_ctrl[1:0] == 2'b01) ? 2 : 4;
            m_bad = !(req_ctrl inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                  || (req_write && req_ctrl[2]);
            if (longint'(req_addr) + longint'(m_n) > longint'(MEM_BYTES)) m_bad = 1'b1;
            if (m_bad) begin
                e_rv[m_a]  = 1'b1;
                e_err[m_a] = 1'b1;
                e_rd[m_a]  = 32'd0;
                busy_end   = m_a;
            end else begin
                m_val = 0;
                for (int k = 0; k < m_n; k++) begin
                    m_ba = req_addr + 32'(k);
                    e_we[m_a + k]   = req_write;
                    e_addr[m_a + k] = m_ba;
                    e_wd[m_a + k]   = req_wdata[8*k +: 8];
                    m_val = m_val + (longint'(ref_mem[m_ba[9:0]]) << (8 * k));
                end
                if (!req_ctrl[2] && m_n < 4 && m_val >= (longint'(1) << (8 * m_n - 1)))
                    m_val = m_val - (longint'(1) << (8 * m_n));
                e_rv[m_a + m_n]  = 1'b1;
                e_err[m_a + m_n] = 1'b0;
                e_rd[m_a + m_n]  = req_write ? 32'd0 : 32'(m_val);
                busy_end = m_a + m_n;
            end
        end
    endtask

    task automatic start_req(input logic w, input logic [2:0] ct, input logic [31:0] ad,
                             input logic [31:0] wd, input bit hold, output int acc);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = w;
        req_ctrl  = ct;
        req_addr  = ad;
        req_wdata = wd;
        acc = -1;
        for (int i = 0; i < 20 && acc < 0; i++) begin
            @(negedge clk);
            if (req_ready) acc = cyc + 1;
            @(posedge clk); #1;
        end
        tests++;
        if (acc < 0) begin
            fails++;
            $display("FAIL accept_timeout: request never accepted within 20 cycles");
        end
        if (!hold) begin
            req_valid = 1'b0;
            req_write = ~req_write;
            req_ctrl  = 3'b111;
            req_addr  = $urandom;
            req_wdata = $urandom;
        end
    endtask

    task automatic wait_resp(output int rc, output logic [31:0] rd, output logic er);
        rc = -1;
        rd = 32'd0;
        er = 1'b0;
        for (int i = 0; i < 20 && rc < 0; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                rc = cyc;
                rd = resp_rdata;
                er = resp_err;
            end
        end
        tests++;
        if (rc < 0) begin
            fails++;
            $display("FAIL resp_timeout: no resp_valid within 20 cycles");
        end
    endtask

    task automatic do_req(input string nm, input logic w, input logic [2:0] ct,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int acc, rc;
        logic [31:0] rd;
        logic er;
        start_req(w, ct, ad, wd, 1'b0, acc);
        wait_resp(rc, rd, er);
        check({nm, " rdata"}, rd, exp_rd);
        check({nm, " err"}, 32'(er), 32'(exp_err));
        check({nm, " latency"}, 32'(rc - acc + 1), 32'(exp_lat));
    endtask

    int acc1, acc2, rc;
    logic [31:0] rd;
    logic er;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_ctrl  = 3'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            mem[i]     <= 8'(i) ^ 8'h5A;
            ref_mem[i]  = 8'(i) ^ 8'h5A;
        end

        fork
            forever begin
                @(negedge clk);
                model_cycle();
            end
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset resp_err", 32'(resp_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_req("SW 0x10", 1'b1, 3'b010, 32'h10, 32'hA1B2C3D4, 32'h0, 1'b0, 5);
        check_mem(32'h10, 8'hD4);
        check_mem(32'h11, 8'hC3);
        check_mem(32'h12, 8'hB2);
        check_mem(32'h13, 8'hA1);
        do_req("LW 0x10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hA1B2C3D4, 1'b0, 5);
        do_req("LH 0x12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFA1B2, 1'b0, 3);
        do_req("LHU 0x12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000A1B2, 1'b0, 3);
        do_req("LB 0x11",  1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFC3, 1'b0, 2);
        do_req("LBU 0x11", 1'b0, 3'b100, 32'h11, 32'h0, 32'h000000C3, 1'b0, 2);

        do_req("SH 0x21", 1'b1, 3'b001, 32'h21, 32'h0000BEEF, 32'h0, 1'b0, 3);
        check_mem(32'h20, 8'h7A);
        check_mem(32'h21, 8'hEF);
        check_mem(32'h22, 8'hBE);

        do_req("LW 0x3FC", 1'b0, 3'b010, 32'h3FC, 32'h0, 32'hA5A4A7A6, 1'b0, 5);
        do_req("LW 0x3FE", 1'b0, 3'b010, 32'h3FE, 32'h0, 32'h0, 1'b1, 1);
        do_req("LH 0x3FF", 1'b0, 3'b001, 32'h3FF, 32'h0, 32'h0, 1'b1, 1);
        do_req("LBU 0xFFFFFFFF", 1'b0, 3'b100, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1);
        do_req("ctrl 011 load", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        do_req("ctrl 111 load", 1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        do_req("ctrl 100 store", 1'b1, 3'b100, 32'h30, 32'h12345678, 32'h0, 1'b1, 1);
        check_mem(32'h30, 8'h6A);

        // reset during the third byte of a word store
        start_req(1'b1, 3'b010, 32'h40, 32'h55667788, 1'b0, acc1);
        while (cyc < acc1 + 2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset req_ready", 32'(req_ready), 32'd1);
        check("post-reset resp_valid", 32'(resp_valid), 32'd0);
        repeat (6) @(posedge clk);
        check_mem(32'h40, 8'h88);
        check_mem(32'h41, 8'h77);
        check_mem(32'h42, 8'h18);
        check_mem(32'h43, 8'h19);

        // valid held high across two requests
        start_req(1'b1, 3'b000, 32'h50, 32'h00000099, 1'b1, acc1);
        start_req(1'b0, 3'b100, 32'h50, 32'h0, 1'b0, acc2);
        check("back-to-back accept spacing", 32'(acc2 - acc1), 32'd3);
        wait_resp(rc, rd, er);
        check("back-to-back LBU rdata", rd, 32'h00000099);
        check("back-to-back LBU latency", 32'(rc - acc2 + 1), 32'd2);
        check_mem(32'h50, 8'h99);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
